gcd_arbiter: RTL and testbench

GCD_ARBITER -- requirements
Module: gcd_arbiter

---
 rtl/gcd_arbiter_if.sv | 34 +++
 rtl/gcd_arbiter.sv | 122 ++++++++++++
 tb/tb_gcd_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_arbiter_if.sv
// Bundle of requester handshakes, result and shared-GCD-core signals for gcd_arbiter.
interface gcd_arbiter_if #(
  parameter int W = 8
);
  logic         req0;
  logic         req1;
  logic [W-1:0] x0;
  logic [W-1:0] y0;
  logic [W-1:0] x1;
  logic [W-1:0] y1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic         err0;
  logic         err1;
  logic [W-1:0] res;
  logic         core_clr;
  logic         core_go;
  logic [W-1:0] core_x;
  logic [W-1:0] core_y;
  logic         core_gld;
  logic [W-1:0] core_gcd;

  modport master (
    output req0, req1, x0, y0, x1, y1, core_gld, core_gcd,
    input  gnt0, gnt1, done0, done1, err0, err1, res, core_clr, core_go, core_x, core_y
  );

  modport slave (
    input  req0, req1, x0, y0, x1, y1, core_gld, core_gcd,
    output gnt0, gnt1, done0, done1, err0, err1, res, core_clr, core_go, core_x, core_y
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Two-requester round-robin front end for a shared subtractive GCD core.
// Each job runs clear -> start -> wait; zero operands and core timeouts end in an error pulse.
module gcd_arbiter #(
  parameter int W   = 8,
  parameter int TMO = 255
) (
  input  logic         clk,
  input  logic         clr,
  gcd_arbiter_if.slave bus
);
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_GO   = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic          grant_s;
  logic          sel_s;
  logic          zero_s;
  logic          tmo_s;
  logic          owner_r;
  logic          last_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  sel_x_s;
  logic [W-1:0]  sel_y_s;
  logic [W-1:0]  res_r;
  logic [W-1:0]  core_x_r;
  logic [W-1:0]  core_y_r;

  // Last WAIT cycle before abort: counter was cleared in GO and is one behind
  assign tmo_s = (cnt_r == CW'(TMO - 1));

  // Requester selection and next-state decode
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 1'b0;
    sel_s      = 1'b0;
    if (bus.req0 && bus.req1) begin
      sel_s = ~last_r;
    end else if (bus.req1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    sel_x_s = sel_s ? bus.x1 : bus.x0;
    sel_y_s = sel_s ? bus.y1 : bus.y0;
    zero_s  = (sel_x_s == {W{1'b0}}) || (sel_y_s == {W{1'b0}});
    case (state_r)
      ST_IDLE: begin
        if (!clr && (bus.req0 || bus.req1)) begin
          grant_s    = 1'b1;
          state_nx_s = zero_s ? ST_ERR : ST_CLR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLR:  state_nx_s = ST_GO;
      ST_GO:   state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.core_gld) begin
          state_nx_s = ST_RESP;
        end else if (tmo_s) begin
          state_nx_s = ST_ERR;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RESP: state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, job context, wait counter and result registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r  <= ST_IDLE;
      owner_r  <= 1'b0;
      last_r   <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      res_r    <= {W{1'b0}};
      core_x_r <= {W{1'b0}};
      core_y_r <= {W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (grant_s) begin
        owner_r  <= sel_s;
        last_r   <= sel_s;
        core_x_r <= sel_x_s;
        core_y_r <= sel_y_s;
      end
      if (state_r == ST_GO) begin
        cnt_r <= {CW{1'b0}};
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if ((state_r == ST_WAIT) && bus.core_gld) begin
        res_r <= bus.core_gcd;
      end
    end
  end

  // Pulses are masked while clr is high so nothing leaks during reset
  assign bus.gnt0     = grant_s & ~sel_s;
  assign bus.gnt1     = grant_s & sel_s;
  assign bus.done0    = ~clr & (state_r == ST_RESP) & ~owner_r;
  assign bus.done1    = ~clr & (state_r == ST_RESP) & owner_r;
  assign bus.err0     = ~clr & (state_r == ST_ERR) & ~owner_r;
  assign bus.err1     = ~clr & (state_r == ST_ERR) & owner_r;
  assign bus.core_clr = ~clr & ((state_r == ST_CLR) || (state_r == ST_ERR));
  assign bus.core_go  = ~clr & (state_r == ST_GO);
  assign bus.res      = res_r;
  assign bus.core_x   = core_x_r;
  assign bus.core_y   = core_y_r;
endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: a behavioural GCD core on one instance, a silent core on a short-timeout instance.
module tb_gcd_arbiter;
  typedef struct packed {
    logic       err;
    logic       who;
    logic [7:0] res;
  } sb_t;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ngnt = 0;
  int   ngo = 0;
  int   t_gnt = 0, t_clr = 0, t_go = 0, t_done = 0;
  int   t_gnt_t = 0, t_err_t = 0, nerr_t = 0, ndone_t = 0;
  logic prev_clr = 1'b0;
  logic [3:0] cd;
  sb_t  sb[$];

  gcd_arbiter_if #(.W(8)) bus ();
  gcd_arbiter_if #(.W(8)) bus_t ();

  gcd_arbiter #(.W(8), .TMO(255)) dut   (.clk(clk), .clr(clr), .bus(bus));
  gcd_arbiter #(.W(8), .TMO(4))   dut_t (.clk(clk), .clr(clr), .bus(bus_t));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    while (b != 8'd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic push(input logic err, input logic who, input logic [7:0] res);
    sb.push_back('{err: err, who: who, res: res});
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check({"drain_", tag}, 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Behavioural core: result flag rises five cycles after core_go, held until core_clr
  always @(posedge clk) begin
    if (clr || bus.core_clr) begin
      bus.core_gld <= 1'b0;
      cd           <= 4'd0;
    end else if (bus.core_go) begin
      bus.core_gcd <= gcd_f(bus.core_x, bus.core_y);
      cd           <= 4'd4;
    end else if (cd != 4'd0) begin
      if (cd == 4'd1) bus.core_gld <= 1'b1;
      cd <= cd - 4'd1;
    end
  end

  // Monitor for the main instance: exclusivity, go-after-clear, scoreboard pops
  always @(negedge clk) begin
    int  np;
    sb_t e;
    np = int'(bus.gnt0) + int'(bus.gnt1) + int'(bus.done0) + int'(bus.done1)
       + int'(bus.err0) + int'(bus.err1);
    if (np != 0) check("onehot", 32'(np), 32'd1);
    if (bus.core_go) begin
      check("go_after_clr", 32'(prev_clr), 32'd1);
      t_go <= cyc;
      ngo  <= ngo + 1;
    end
    prev_clr <= bus.core_clr;
    if (bus.gnt0 || bus.gnt1) begin
      t_gnt <= cyc;
      ngnt  <= ngnt + 1;
    end
    if (bus.core_clr) t_clr <= cyc;
    if (bus.done0 || bus.done1 || bus.err0 || bus.err1) begin
      t_done <= cyc;
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("kind", 32'(bus.err0 | bus.err1), 32'(e.err));
        check("who", 32'(bus.done1 | bus.err1), 32'(e.who));
        check("res", 32'(bus.res), 32'(e.res));
        if (e.err) check("err_core_clr", 32'(bus.core_clr), 32'd1);
      end
    end
  end

  // Monitor for the short-timeout instance
  always @(negedge clk) begin
    if (bus_t.gnt0) t_gnt_t <= cyc;
    if (bus_t.err0) begin
      t_err_t <= cyc;
      nerr_t  <= nerr_t + 1;
      check("tmo_err_clr", 32'(bus_t.core_clr), 32'd1);
    end
    if (bus_t.done0 || bus_t.done1) ndone_t <= ndone_t + 1;
  end

  initial begin
    int n;
    int ngo0;
    clr = 1'b1;
    bus.req0 = 1'b1;  bus.req1 = 1'b1;
    bus.x0 = 8'd12;   bus.y0 = 8'd8;
    bus.x1 = 8'd9;    bus.y1 = 8'd6;
    bus_t.req0 = 1'b0; bus_t.req1 = 1'b0;
    bus_t.x0 = 8'd0;  bus_t.y0 = 8'd0;
    bus_t.x1 = 8'd0;  bus_t.y1 = 8'd0;
    bus_t.core_gld = 1'b0;
    bus_t.core_gcd = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    check("rst_pulses", 32'({bus.done0, bus.done1, bus.err0, bus.err1, bus.core_clr, bus.core_go}), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_core_x", 32'(bus.core_x), 32'd0);
    check("rst_core_y", 32'(bus.core_y), 32'd0);

    // Both requesting straight out of reset: 0 first, then strict alternation
    push(1'b0, 1'b0, 8'd4); push(1'b0, 1'b1, 8'd3);
    push(1'b0, 1'b0, 8'd4); push(1'b0, 1'b1, 8'd3);
    @(posedge clk); #1;
    clr = 1'b0;
    n = 0;
    while (ngnt < 4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("rr_grants", 32'(ngnt), 32'd4);
    drain("rr", 200);

    // Single job latency
    bus.x0 = 8'd12; bus.y0 = 8'd8;
    push(1'b0, 1'b0, 8'd4);
    bus.req0 = 1'b1;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    drain("single", 100);
    check("lat_clr", 32'(t_clr - t_gnt), 32'd1);
    check("lat_go", 32'(t_go - t_gnt), 32'd2);
    check("lat_done", 32'(t_done - t_gnt), 32'd8);

    // Zero operand rejected without starting the core, result kept
    ngo0 = ngo;
    bus.x1 = 8'd0; bus.y1 = 8'd5;
    push(1'b1, 1'b1, 8'd4);
    bus.req1 = 1'b1;
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    drain("zero", 50);
    check("zero_nogo", 32'(ngo - ngo0), 32'd0);
    check("zero_lat", 32'(t_done - t_gnt), 32'd1);

    // Silent core on the TMO=4 instance
    bus_t.x0 = 8'd7; bus_t.y0 = 8'd3;
    bus_t.req0 = 1'b1;
    @(posedge clk); #1;
    bus_t.req0 = 1'b0;
    n = 0;
    while (nerr_t < 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_err", 32'(nerr_t), 32'd1);
    check("tmo_lat", 32'(t_err_t - t_gnt_t), 32'd7);
    check("tmo_res", 32'(bus_t.res), 32'd0);
    bus_t.req0 = 1'b1;
    #1;
    check("tmo_idle_gnt", 32'(bus_t.gnt0), 32'd1);
    @(posedge clk); #1;
    bus_t.req0 = 1'b0;
    n = 0;
    while (nerr_t < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_err2", 32'(nerr_t), 32'd2);

    // Reset pulse in the middle of WAIT abandons the job silently
    bus.x0 = 8'd20; bus.y0 = 8'd8;
    bus.req0 = 1'b1;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_pulses", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                                 bus.core_clr, bus.core_go}), 32'd0);
    check("mid_rst_res", 32'(bus.res), 32'd0);
    check("mid_rst_core_xy", 32'({bus.core_x, bus.core_y}), 32'd0);
    clr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    bus.x0 = 8'd15; bus.y0 = 8'd10;
    push(1'b0, 1'b0, 8'd5);
    bus.req0 = 1'b1;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    drain("after_rst", 100);
    check("after_rst_lat_go", 32'(t_go - t_gnt), 32'd2);
    check("tmo_nodone", 32'(ndone_t), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
